// File: rtl/w7_fetch_seq.sv
// Read-side sequencer for the F7 weight ROM: walks addresses 0..DEPTH-1,
// realigns ROM data with a tag pipe matching RD_LAT, buffers rows in a small
// FIFO and streams them out over valid/ready with lossless backpressure.
module w7_fetch_seq #(
  parameter int DEPTH  = 84,
  parameter int AW     = 7,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] w7_raddr,
  input  logic [7:0]    w7_1_rdata,
  input  logic [7:0]    w7_2_rdata,
  input  logic [7:0]    w7_3_rdata,
  input  logic [7:0]    w7_4_rdata,
  input  logic [7:0]    w7_5_rdata,
  input  logic [7:0]    w7_6_rdata,
  input  logic [7:0]    w7_7_rdata,
  input  logic [7:0]    w7_8_rdata,
  input  logic [7:0]    w7_9_rdata,
  input  logic [7:0]    w7_10_rdata,
  output logic [79:0]   w_data,
  output logic [AW-1:0] w_idx,
  output logic          w_last,
  output logic          w_valid,
  input  logic          w_ready
);

  localparam int FD = RD_LAT + 1;
  localparam int PW = (FD > 2) ? 2 : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] raddr_q;
  logic          issue;
  logic          push;
  logic          pop;
  logic [2:0]    inflight;
  logic [79:0]   row;

  logic          pipe_vld_q [RD_LAT];
  logic [AW-1:0] pipe_idx_q [RD_LAT];

  logic [79:0]   mem_data_q [FD];
  logic [AW-1:0] mem_idx_q  [FD];
  logic          mem_last_q [FD];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0]    fifo_cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop     = w_valid && w_ready;
  assign push    = pipe_vld_q[RD_LAT-1];
  assign row     = {w7_10_rdata, w7_9_rdata, w7_8_rdata, w7_7_rdata, w7_6_rdata,
                    w7_5_rdata, w7_4_rdata, w7_3_rdata, w7_2_rdata, w7_1_rdata};
  assign busy    = (state_q != S_IDLE);
  assign w_valid = (fifo_cnt_q != 3'd0);
  assign w_data  = mem_data_q[rd_ptr_q];
  assign w_idx   = mem_idx_q[rd_ptr_q];
  assign w_last  = mem_last_q[rd_ptr_q];

  // The address is presented combinationally in the issue cycle so the tag
  // pipe only needs RD_LAT stages; otherwise the last issued address is held.
  assign w7_raddr = issue ? cnt_q : raddr_q;

  // Count tags currently travelling through the read-latency pipe.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {2'b00, pipe_vld_q[i]};
    end
  end

  // Next-state, credit-gated issue and completion pulse.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // fifo + inflight - pop < FD, rearranged to avoid subtraction
        issue = (fifo_cnt_q + inflight) < (3'(FD) + {2'b00, pop});
        if (issue && cnt_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && w_last && fifo_cnt_q == 3'd1 && inflight == '0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, issue counter and held read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= w7_raddr;
      if (state_q == S_IDLE && start) begin
        cnt_q <= '0;
      end else if (issue && cnt_q != LAST_IDX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Tag shift pipe aligning issued indices with ROM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_idx_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= issue;
      pipe_idx_q[0] <= cnt_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  // Row FIFO: capture on tag exit, release on downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int unsigned i = 0; i < FD; i++) begin
        mem_data_q[i] <= '0;
        mem_idx_q[i]  <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q] <= row;
        mem_idx_q[wr_ptr_q]  <= pipe_idx_q[RD_LAT-1];
        mem_last_q[wr_ptr_q] <= (pipe_idx_q[RD_LAT-1] == LAST_IDX);
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + 3'd1;
      end else if (!push && pop) begin
        fifo_cnt_q <= fifo_cnt_q - 3'd1;
      end
    end
  end

  // The credit rule must never let a write land on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && fifo_cnt_q == 3'(FD)));
  end

endmodule

// File: tb/tb_w7_fetch_seq.sv
// Bench for w7_fetch_seq: three instances (84/lat1, 84/lat2, 1/lat1) share a
// clock; a model ROM returns lane k = addr + k, and each accepted beat is
// compared with the next expected row index.
module tb_w7_fetch_seq;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic w_ready = 1'b0;
  logic [1:0] sel = 2'd0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic          busy_o  [3];
  logic          done_o  [3];
  logic [AW-1:0] raddr_o [3];
  logic [79:0]   data_o  [3];
  logic [AW-1:0] idx_o   [3];
  logic          last_o  [3];
  logic          valid_o [3];
  logic          start_v [3];
  logic [AW-1:0] a0, a1p, a1, a2;
  logic [7:0]    ln0 [10];
  logic [7:0]    ln1 [10];
  logic [7:0]    ln2 [10];

  logic          m_busy, m_done, m_last, m_valid;
  logic [AW-1:0] m_raddr, m_idx;
  logic [79:0]   m_data;

  assign start_v[0] = start && (sel == 2'd0);
  assign start_v[1] = start && (sel == 2'd1);
  assign start_v[2] = start && (sel == 2'd2);
  assign m_busy  = busy_o[sel];
  assign m_done  = done_o[sel];
  assign m_raddr = raddr_o[sel];
  assign m_data  = data_o[sel];
  assign m_idx   = idx_o[sel];
  assign m_last  = last_o[sel];
  assign m_valid = valid_o[sel];

  // Model ROMs: read latency 1 for instances 0 and 2, latency 2 for instance 1.
  always_ff @(posedge clk) begin
    a0  <= raddr_o[0];
    a1p <= raddr_o[1];
    a1  <= a1p;
    a2  <= raddr_o[2];
  end

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      ln0[k] = 8'(32'(a0) + k + 1);
      ln1[k] = 8'(32'(a1) + k + 1);
      ln2[k] = 8'(32'(a2) + k + 1);
    end
  end

  w7_fetch_seq #(.DEPTH(84), .AW(AW), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_o[0]), .done(done_o[0]),
    .w7_raddr(raddr_o[0]),
    .w7_1_rdata(ln0[0]), .w7_2_rdata(ln0[1]), .w7_3_rdata(ln0[2]), .w7_4_rdata(ln0[3]),
    .w7_5_rdata(ln0[4]), .w7_6_rdata(ln0[5]), .w7_7_rdata(ln0[6]), .w7_8_rdata(ln0[7]),
    .w7_9_rdata(ln0[8]), .w7_10_rdata(ln0[9]),
    .w_data(data_o[0]), .w_idx(idx_o[0]), .w_last(last_o[0]), .w_valid(valid_o[0]),
    .w_ready(w_ready));

  w7_fetch_seq #(.DEPTH(84), .AW(AW), .RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_o[1]), .done(done_o[1]),
    .w7_raddr(raddr_o[1]),
    .w7_1_rdata(ln1[0]), .w7_2_rdata(ln1[1]), .w7_3_rdata(ln1[2]), .w7_4_rdata(ln1[3]),
    .w7_5_rdata(ln1[4]), .w7_6_rdata(ln1[5]), .w7_7_rdata(ln1[6]), .w7_8_rdata(ln1[7]),
    .w7_9_rdata(ln1[8]), .w7_10_rdata(ln1[9]),
    .w_data(data_o[1]), .w_idx(idx_o[1]), .w_last(last_o[1]), .w_valid(valid_o[1]),
    .w_ready(w_ready));

  w7_fetch_seq #(.DEPTH(1), .AW(AW), .RD_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_o[2]), .done(done_o[2]),
    .w7_raddr(raddr_o[2]),
    .w7_1_rdata(ln2[0]), .w7_2_rdata(ln2[1]), .w7_3_rdata(ln2[2]), .w7_4_rdata(ln2[3]),
    .w7_5_rdata(ln2[4]), .w7_6_rdata(ln2[5]), .w7_7_rdata(ln2[6]), .w7_8_rdata(ln2[7]),
    .w7_9_rdata(ln2[8]), .w7_10_rdata(ln2[9]),
    .w_data(data_o[2]), .w_idx(idx_o[2]), .w_last(last_o[2]), .w_valid(valid_o[2]),
    .w_ready(w_ready));

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] exp_row(input int i);
    logic [79:0] r;
    r = '0;
    for (int k = 1; k <= 10; k++) r[8*k-1 -: 8] = 8'((i + k) % 256);
    return r;
  endfunction

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"},  m_busy,  0);
    chk({pfx, "_done"},  m_done,  0);
    chk({pfx, "_raddr"}, m_raddr, 0);
    chk({pfx, "_valid"}, m_valid, 0);
    chk({pfx, "_data"},  m_data,  0);
    chk({pfx, "_idx"},   m_idx,   0);
    chk({pfx, "_last"},  m_last,  0);
  endtask

  // mode: 0 ready=1, 1 alternating, 2 stalled 20 cycles, 3 random,
  //       4 second start at beat 30, 5 reset at beat 40
  task automatic run(input logic [1:0] s, input int mode, input int depth, input int lat);
    int beats, dones, first_v, base, cyc;
    logic pv, pr, acc, fin, post;
    logic [79:0] pd;
    logic [AW-1:0] pi;
    sel = s; beats = 0; dones = 0; first_v = -1; pv = 0; pr = 0;
    pd = '0; pi = '0; fin = 0; post = 0;
    base = (mode == 2) ? 21 : 2 + lat;
    @(negedge clk);
    start = 1'b1;
    w_ready = 1'b1;
    cyc = 1;
    while (cyc <= 600 && !fin) begin
      @(negedge clk);
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        #1;
        chk_reset_vals("midrun_rst");
        chk("midrun_no_done", dones, 0);
        fin = 1;
      end else begin
        case (mode)
          1:       w_ready = cyc[0];
          2:       w_ready = (cyc > 20);
          3:       w_ready = 1'($urandom_range(0, 1));
          default: w_ready = 1'b1;
        endcase
        #1;
        if (post) begin
          chk("busy_after_done", m_busy, 0);
          chk("valid_after_done", m_valid, 0);
          fin = 1;
        end else begin
          if (cyc == 1) begin
            chk("busy_c1", m_busy, 1);
            if (mode == 0) chk("raddr_c1", m_raddr, 0);
          end
          if (m_valid && first_v < 0) begin
            first_v = cyc;
            if (mode == 0) chk("first_valid_cycle", cyc, 2 + lat);
          end
          if (pv && !pr) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_idx", m_idx, pi);
            chk("hold_data", m_data, pd);
          end
          if (mode == 2 && cyc == 20) begin
            chk("stall_raddr", m_raddr, lat);
            chk("stall_valid", m_valid, 1);
            chk("stall_idx", m_idx, 0);
          end
          acc = m_valid && w_ready;
          chk("done", m_done, acc && (beats == depth - 1));
          if (acc) begin
            chk("idx", m_idx, beats);
            chk("data", m_data, exp_row(beats));
            chk("last", m_last, beats == depth - 1);
            if (mode == 0 || mode == 2 || mode == 4) chk("beat_cycle", cyc, base + beats);
            beats++;
          end
          if (m_done) begin
            dones++;
            post = 1;
          end
          pv = m_valid; pr = w_ready; pd = m_data; pi = m_idx;
          if (mode == 4 && acc && beats == 30) start = 1'b1;
          if (mode == 5 && acc && beats == 40) rst = 1'b1;
        end
      end
      cyc++;
    end
    chk("run_finished", fin, 1);
    if (mode != 5) begin
      chk("beat_count", beats, depth);
      chk("done_count", dones, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk_reset_vals("reset");
    end
    rst = 1'b0;
    run(2'd0, 0, 84, 1);
    run(2'd0, 1, 84, 1);
    run(2'd0, 2, 84, 1);
    run(2'd0, 3, 84, 1);
    run(2'd0, 4, 84, 1);
    run(2'd0, 5, 84, 1);
    run(2'd0, 0, 84, 1);
    run(2'd1, 0, 84, 2);
    run(2'd1, 1, 84, 2);
    run(2'd1, 2, 84, 2);
    run(2'd1, 3, 84, 2);
    run(2'd2, 0, 1, 1);
    run(2'd2, 3, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
